// File: rtl/seg_scan_mux.sv
// Purpose : time-multiplexes NUM_DIGITS active-low segment patterns onto one shared 8-bit bus,
//           with a dead-time between digits so a previous pattern never ghosts onto the next digit.
// Latency : all outputs registered; segmentsIn is captured on the edge that ends the BLANK dead-time.
// Backpressure: none; enableIn low forces the display dark on the next edge and holds the scan position.
//
// Ports:
//   clkIn            system clock
//   resetIn          synchronous, active-high reset
//   enableIn         scan enable; low blanks the display and parks the scan on the current digit
//   brightnessIn     [3:0] PWM duty, captured at ON entry (present only with SEG_SCAN_DIM_EN)
//   segmentsIn       digit k pattern in bits [8k+7:8k], {a,b,c,d,e,f,g,dp}, active-low
//   segmentEnableOut active-low segment bus, same bit order as segmentsIn
//   digitEnableOut   one-hot digit select in the polarity set by DIGIT_ACTIVE_LOW
//   frameStartOut    one-cycle pulse on the first lit cycle of digit 0
//
// Optional build macro: SEG_SCAN_DIM_EN adds PWM brightness control of the digit enables.

module seg_scan_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int DIGIT_TICKS      = 6750,
    parameter int BLANK_TICKS      = 270,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                    clkIn,
    input  logic                    resetIn,
    input  logic                    enableIn,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]              brightnessIn,
`endif
    input  logic [8*NUM_DIGITS-1:0] segmentsIn,
    output logic [7:0]              segmentEnableOut,
    output logic [NUM_DIGITS-1:0]   digitEnableOut,
    output logic                    frameStartOut
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);
    localparam int IDX_W     = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Idle level of the digit enables: all ones for active-low drivers, all zeros otherwise.
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF =
        (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : gBadDigits
        $error("seg_scan_mux: NUM_DIGITS must be in 2..8");
    end
    if (DIGIT_TICKS < 1) begin : gBadDigitTicks
        $error("seg_scan_mux: DIGIT_TICKS must be >= 1");
    end
    if (BLANK_TICKS < 1) begin : gBadBlankTicks
        $error("seg_scan_mux: BLANK_TICKS must be >= 1");
    end

    logic [0:0]            state;
    logic [CNT_W-1:0]      tickCnt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idxNext;
    logic [7:0]            selSeg;
    logic [NUM_DIGITS-1:0] selOneHot;
    logic [NUM_DIGITS-1:0] digitOn;

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] pwmCnt;
    logic [3:0] pwmNext;
    logic [3:0] brightReg;

    assign pwmNext = pwmCnt + 4'd1;
`endif

    // Pattern and enable vector for the digit currently addressed by idx.
    always_comb begin
        selSeg    = 8'hFF;
        selOneHot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                selSeg       = segmentsIn[8*k +: 8];
                selOneHot[k] = 1'b1;
            end
        end
    end

    assign digitOn = selOneHot ^ DIGIT_OFF;
    assign idxNext = (idx == IDX_LAST) ? '0 : idx + IDX_ONE;

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state            <= ST_BLANK;
            tickCnt          <= '0;
            idx              <= '0;
            segmentEnableOut <= 8'hFF;
            digitEnableOut   <= DIGIT_OFF;
            frameStartOut    <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
            pwmCnt           <= '0;
            brightReg        <= 4'hF;
`endif
        end else if (!enableIn) begin
            // Park dark at the start of a dead-time; idx is kept so no digit is skipped.
            state            <= ST_BLANK;
            tickCnt          <= '0;
            segmentEnableOut <= 8'hFF;
            digitEnableOut   <= DIGIT_OFF;
            frameStartOut    <= 1'b0;
        end else begin
            frameStartOut <= 1'b0;
            case (state)
                ST_BLANK: begin
                    if (tickCnt == BLANK_LAST) begin
                        // Segments and digit switch on the same edge, so the bus never
                        // carries one digit's pattern while another digit is enabled.
                        state            <= ST_ON;
                        tickCnt          <= '0;
                        segmentEnableOut <= selSeg;
                        digitEnableOut   <= digitOn;
                        frameStartOut    <= (idx == '0);
`ifdef SEG_SCAN_DIM_EN
                        pwmCnt           <= '0;
                        brightReg        <= brightnessIn;
`endif
                    end else begin
                        tickCnt <= tickCnt + CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (tickCnt == DIGIT_LAST) begin
                        state            <= ST_BLANK;
                        tickCnt          <= '0;
                        segmentEnableOut <= 8'hFF;
                        digitEnableOut   <= DIGIT_OFF;
                        idx              <= idxNext;
                    end else begin
                        tickCnt <= tickCnt + CNT_ONE;
`ifdef SEG_SCAN_DIM_EN
                        // Registered enable reflects the PWM count of the coming cycle.
                        pwmCnt         <= pwmNext;
                        digitEnableOut <= (pwmNext <= brightReg) ? digitOn : DIGIT_OFF;
`endif
                    end
                end
                default: begin
                    state   <= ST_BLANK;
                    tickCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Purpose : bench for seg_scan_mux with 4 digits, 8 lit cycles and 2 dead cycles per slot.
// Latency : n/a (bench).
// Backpressure: n/a (bench).

module tb_seg_scan_mux;

    localparam int ND    = 4;
    localparam int DT    = 8;
    localparam int BT    = 2;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = ND * SLOT;

    logic            clkIn      = 1'b0;
    logic            resetIn    = 1'b1;
    logic            enableIn   = 1'b1;
    logic [8*ND-1:0] segmentsIn = 32'hC0F9A4B0;
`ifdef SEG_SCAN_DIM_EN
    logic [3:0]      brightnessIn = 4'd15;
`endif
    logic [7:0]      segmentEnableOut;
    logic [ND-1:0]   digitEnableOut;
    logic            frameStartOut;

    int checks = 0;
    int errors = 0;
    int absCyc = 0;
    int base   = 0;
    int phase  = 0;

    // Model: position within the frame since the last start, the digit the timeline started on,
    // and the pattern/brightness captured just before the current lit window.
    int         mP     = 0;
    int         mD0    = 0;
    logic [7:0] mLat   = 8'hFF;
    logic [3:0] mBright = 4'd15;
    bit         mValid = 1'b0;

    typedef struct {
        int         ph;
        int         cyc;
        logic [7:0] seg;
        logic [3:0] dig;
        logic       fs;
    } lit_t;

    localparam int NLIT = 23;
    lit_t lits [NLIT] = '{
        '{1,  0, 8'hFF, 4'hF, 1'b0}, '{1,  1, 8'hFF, 4'hF, 1'b0},
        '{1,  2, 8'hB0, 4'hE, 1'b1}, '{1,  3, 8'hB0, 4'hE, 1'b0},
        '{1,  9, 8'hB0, 4'hE, 1'b0}, '{1, 10, 8'hFF, 4'hF, 1'b0},
        '{1, 12, 8'hA4, 4'hD, 1'b0}, '{1, 22, 8'hF9, 4'hB, 1'b0},
        '{1, 32, 8'hC0, 4'h7, 1'b0}, '{1, 41, 8'hFF, 4'hF, 1'b0},
        '{1, 42, 8'h99, 4'hE, 1'b1},
        '{2, 14, 8'hA4, 4'hD, 1'b0}, '{2, 15, 8'hFF, 4'hF, 1'b0},
        '{2, 21, 8'hFF, 4'hF, 1'b0}, '{2, 22, 8'hA4, 4'hD, 1'b0},
        '{2, 29, 8'hA4, 4'hD, 1'b0}, '{2, 30, 8'hFF, 4'hF, 1'b0},
        '{2, 32, 8'hF9, 4'hB, 1'b0},
        '{3, 25, 8'hF9, 4'hB, 1'b0},
        '{4,  0, 8'hFF, 4'hF, 1'b0}, '{4,  1, 8'hFF, 4'hF, 1'b0},
        '{4,  2, 8'hB0, 4'hE, 1'b1}, '{4,  3, 8'hB0, 4'hE, 1'b0}
    };

`ifdef SEG_SCAN_DIM_EN
    localparam int NDIM = 7;
    lit_t dimLits [NDIM] = '{
        '{5,  2, 8'hB0, 4'hE, 1'b1}, '{5,  5, 8'hB0, 4'hE, 1'b0},
        '{5,  6, 8'hB0, 4'hF, 1'b0}, '{5,  9, 8'hB0, 4'hF, 1'b0},
        '{5, 10, 8'hFF, 4'hF, 1'b0}, '{5, 12, 8'hA4, 4'hD, 1'b0},
        '{5, 19, 8'hA4, 4'hD, 1'b0}
    };
`endif

    seg_scan_mux #(
        .NUM_DIGITS      (ND),
        .DIGIT_TICKS     (DT),
        .BLANK_TICKS     (BT),
        .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clkIn           (clkIn),
        .resetIn         (resetIn),
        .enableIn        (enableIn),
`ifdef SEG_SCAN_DIM_EN
        .brightnessIn    (brightnessIn),
`endif
        .segmentsIn      (segmentsIn),
        .segmentEnableOut(segmentEnableOut),
        .digitEnableOut  (digitEnableOut),
        .frameStartOut   (frameStartOut)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn) absCyc <= absCyc + 1;

    function automatic int slotDigit(input int p, input int d0);
        return (d0 + p / SLOT) % ND;
    endfunction

    always @(posedge clkIn) begin
        if (resetIn) begin
            mP     = 0;
            mD0    = 0;
            mValid = 1'b1;
        end else if (!enableIn) begin
            mD0 = slotDigit(mP, mD0);
            mP  = 0;
        end else begin
            if (mP % SLOT == BT - 1) begin
                mLat = segmentsIn[8*slotDigit(mP, mD0) +: 8];
`ifdef SEG_SCAN_DIM_EN
                mBright = brightnessIn;
`endif
            end
            mP = (mP + 1) % FRAME;
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d phase=%0d got %h expected %h",
                     nm, absCyc - base, phase, got, exp);
        end
    endtask

    always @(negedge clkIn) begin
        int            o;
        int            dg;
        bit            lit;
        logic [7:0]    eSeg;
        logic [ND-1:0] eDig;
        logic          eFs;
        if (mValid) begin
            o    = mP % SLOT;
            dg   = slotDigit(mP, mD0);
            lit  = (o >= BT);
            eSeg = lit ? mLat : 8'hFF;
            eDig = '1;
`ifdef SEG_SCAN_DIM_EN
            if (lit && ((o - BT) % 16) <= int'(mBright)) eDig[dg] = 1'b0;
`else
            if (lit) eDig[dg] = 1'b0;
`endif
            eFs = lit && (o == BT) && (dg == 0);
            chk("model_seg", segmentEnableOut, eSeg);
            chk("model_dig", {4'h0, digitEnableOut}, {4'h0, eDig});
            chk("model_frame", {7'd0, frameStartOut}, {7'd0, eFs});
            chk("one_active", {7'd0, ($countones(~digitEnableOut) <= 1)}, 8'd1);
`ifndef SEG_SCAN_DIM_EN
            if (digitEnableOut == '1) chk("dark_seg", segmentEnableOut, 8'hFF);
`endif
            for (int i = 0; i < NLIT; i++) begin
                if (lits[i].ph == phase && lits[i].cyc == absCyc - base) begin
                    chk("lit_seg", segmentEnableOut, lits[i].seg);
                    chk("lit_dig", {4'h0, digitEnableOut}, {4'h0, lits[i].dig});
                    chk("lit_frame", {7'd0, frameStartOut}, {7'd0, lits[i].fs});
                end
            end
`ifdef SEG_SCAN_DIM_EN
            for (int i = 0; i < NDIM; i++) begin
                if (dimLits[i].ph == phase && dimLits[i].cyc == absCyc - base) begin
                    chk("dim_seg", segmentEnableOut, dimLits[i].seg);
                    chk("dim_dig", {4'h0, digitEnableOut}, {4'h0, dimLits[i].dig});
                    chk("dim_frame", {7'd0, frameStartOut}, {7'd0, dimLits[i].fs});
                end
            end
`endif
        end
    end

    // Inputs change shortly after the rising edge, well clear of both sampling points.
    task automatic step();
        @(posedge clkIn);
        #2;
    endtask

    task automatic waitCyc(input int n);
        while ((absCyc - base) < n) step();
    endtask

    task automatic doReset(input int ph);
        phase   = 0;
        resetIn = 1'b1;
        step();
        step();
        resetIn = 1'b0;
        base    = absCyc;
        phase   = ph;
    endtask

    initial begin
        // Scan order, slot timing and mid-slot pattern change.
        segmentsIn = 32'hC0F9A4B0;
        enableIn   = 1'b1;
        doReset(1);
        waitCyc(5);
        segmentsIn[7:0] = 8'h99;
        waitCyc(43);

        // Enable dropped while digit 1 is lit.
        segmentsIn = 32'hC0F9A4B0;
        doReset(2);
        waitCyc(14);
        enableIn = 1'b0;
        waitCyc(20);
        enableIn = 1'b1;
        waitCyc(33);

        // Reset in the middle of digit 2's slot.
        doReset(3);
        waitCyc(25);
        resetIn = 1'b1;
        step();
        resetIn = 1'b0;
        base    = absCyc;
        phase   = 4;
        waitCyc(4);

`ifdef SEG_SCAN_DIM_EN
        brightnessIn = 4'd3;
        doReset(5);
        waitCyc(10);
        brightnessIn = 4'd15;
        waitCyc(20);
`endif

        phase = 6;
        repeat (1000 * FRAME) begin
            step();
            segmentsIn = $urandom;
            enableIn   = ($urandom_range(0, 15) != 0);
`ifdef SEG_SCAN_DIM_EN
            brightnessIn = 4'($urandom_range(0, 15));
`endif
        end
        enableIn = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
